// File: rtl/coord_stepper_pkg.sv
// Shared constants for the Mandelbrot coordinate stepper: config addresses,
// reset coordinates derived from the coordinate width, and the demo FSM states.
package mandel_coord_pkg;

  localparam logic [1:0] CFG_LEFT  = 2'd0;
  localparam logic [1:0] CFG_TOP   = 2'd1;
  localparam logic [1:0] CFG_SCALE = 2'd2;
  localparam logic [1:0] CFG_RSVD  = 2'd3;

  typedef enum logic {DEMO_IDLE, DEMO_UPDATE} demo_state_e;

  // x carries bits-3 fraction bits, so -2.0 is -(2 << (bits-3)).
  function automatic int default_left(input int bits);
    return -(2 << (bits - 3));
  endfunction

  // y shares the fraction width of x; 1.5 = 3 << (bits-4).
  function automatic int default_top(input int bits);
    return 3 << (bits - 4);
  endfunction

  function automatic int default_scale(input int bits);
    return (bits >= 16) ? (240 << (bits - 16)) : (240 >> (16 - bits));
  endfunction

endpackage

// File: rtl/coord_stepper_if.sv
// Bus between the video timing side (strobes, config) and the coordinate stepper.
interface coord_stepper_if #(
  parameter int BITS = 16
);
  // Strobes and config writes are single-cycle pulses with no ready: the
  // stepper accepts every asserted strobe on the edge where it is high.
  logic            cfg_wr;
  logic [1:0]      cfg_addr;
  logic [BITS-4:0] cfg_data;
  logic            demo_en;
  logic            next_pixel;
  logic            next_row;
  logic            next_frame;
  logic [BITS-1:0] x0;
  logic [BITS-2:0] y0;
  logic            cfg_pending;
  logic            demo_busy;

  modport master (
    output cfg_wr, cfg_addr, cfg_data, demo_en, next_pixel, next_row, next_frame,
    input  x0, y0, cfg_pending, demo_busy
  );

  modport slave (
    input  cfg_wr, cfg_addr, cfg_data, demo_en, next_pixel, next_row, next_frame,
    output x0, y0, cfg_pending, demo_busy
  );
endinterface

// File: rtl/coord_shadow_reg.sv
// Shadow/live register pair: writes land in the shadow, commit copies it to live,
// and a lower-priority load lets the demo overwrite live directly.
module coord_shadow_reg #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             commit_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] live_o,
  output logic [WIDTH-1:0] live_d_o
);

  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] live_q, live_d;

  // Commit reads the post-write shadow so a same-cycle write is included.
  always_comb begin
    shadow_d = wr_i ? wdata_i : shadow_q;
    live_d   = live_q;
    if (commit_i)    live_d = shadow_d;
    else if (load_i) live_d = load_val_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= RESET_VAL;
      live_q   <= RESET_VAL;
    end else begin
      shadow_q <= shadow_d;
      live_q   <= live_d;
    end
  end

  assign live_o   = live_q;
  assign live_d_o = live_d;

endmodule

// File: rtl/coord_stepper.sv
// Steps the Mandelbrot pixel coordinate per pixel/row/frame with atomic config commit.
// Define COORD_DEMO_ZOOM_EN to include the per-frame zoom demo FSM.
module coord_stepper
  import mandel_coord_pkg::*;
#(
  parameter int BITS       = 16,
  parameter int SCALE_BITS = 10,
  parameter int H_PIXELS   = 640,
  parameter int V_PIXELS   = 480,
  parameter int MIN_SCALE  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  coord_stepper_if.slave bus,
  output demo_state_e dbg_demo_state_o
);

  localparam logic [BITS-1:0]       LEFT_RST  = BITS'(default_left(BITS));
  localparam logic [BITS-2:0]       TOP_RST   = (BITS-1)'(default_top(BITS));
  localparam logic [SCALE_BITS-1:0] SCALE_RST = SCALE_BITS'(default_scale(BITS));

  logic                  wr_ok, commit, demo_upd;
  logic [BITS-1:0]       left_live, left_d, left_demo;
  logic [BITS-2:0]       top_live, top_d, top_demo;
  logic [SCALE_BITS-1:0] scale_live, scale_demo, unused_scale_d;
  logic [BITS-1:0]       step_x;
  logic [BITS-2:0]       step_y;
  logic [BITS-1:0]       x_q, xrs_q;
  logic [BITS-2:0]       y_q, yrs_q;
  logic                  pending_q;

  assign wr_ok  = bus.cfg_wr && (bus.cfg_addr != CFG_RSVD);
  assign commit = bus.next_frame && (pending_q || wr_ok);
  assign step_x = {{(BITS-SCALE_BITS){1'b0}}, scale_live};
  assign step_y = {{(BITS-1-SCALE_BITS){1'b0}}, scale_live};

  coord_shadow_reg #(.WIDTH(BITS), .RESET_VAL(LEFT_RST)) u_left (
    .clk(clk), .rst_n(rst_n),
    .wr_i(wr_ok && bus.cfg_addr == CFG_LEFT), .wdata_i({bus.cfg_data, 3'b000}),
    .commit_i(commit), .load_i(demo_upd), .load_val_i(left_demo),
    .live_o(left_live), .live_d_o(left_d)
  );

  coord_shadow_reg #(.WIDTH(BITS-1), .RESET_VAL(TOP_RST)) u_top (
    .clk(clk), .rst_n(rst_n),
    .wr_i(wr_ok && bus.cfg_addr == CFG_TOP), .wdata_i({bus.cfg_data, 2'b00}),
    .commit_i(commit), .load_i(demo_upd), .load_val_i(top_demo),
    .live_o(top_live), .live_d_o(top_d)
  );

  coord_shadow_reg #(.WIDTH(SCALE_BITS), .RESET_VAL(SCALE_RST)) u_scale (
    .clk(clk), .rst_n(rst_n),
    .wr_i(wr_ok && bus.cfg_addr == CFG_SCALE), .wdata_i(bus.cfg_data[SCALE_BITS-1:0]),
    .commit_i(commit), .load_i(demo_upd), .load_val_i(scale_demo),
    .live_o(scale_live), .live_d_o(unused_scale_d)
  );

`ifdef COORD_DEMO_ZOOM_EN
  demo_state_e state_q;
  logic        busy_q;
  logic        demo_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DEMO_IDLE;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        DEMO_IDLE: if (bus.next_frame && bus.demo_en && !commit) begin
          state_q <= DEMO_UPDATE;
          busy_q  <= 1'b1;
        end
        DEMO_UPDATE: begin
          state_q <= DEMO_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Shrinking the step by one LSB while shifting the origin by half a screen
  // keeps the centre pixel fixed.
  assign demo_wrap        = (scale_live <= SCALE_BITS'(MIN_SCALE));
  assign demo_upd         = (state_q == DEMO_UPDATE);
  assign left_demo        = demo_wrap ? LEFT_RST  : left_live + BITS'(H_PIXELS / 2);
  assign top_demo         = demo_wrap ? TOP_RST   : top_live - (BITS-1)'(V_PIXELS / 2);
  assign scale_demo       = demo_wrap ? SCALE_RST : scale_live - 1'b1;
  assign bus.demo_busy    = busy_q;
  assign dbg_demo_state_o = state_q;
`else
  logic unused_demo_en;
  assign unused_demo_en   = bus.demo_en;
  assign demo_upd         = 1'b0;
  assign left_demo        = left_live;
  assign top_demo         = top_live;
  assign scale_demo       = scale_live;
  assign bus.demo_busy    = 1'b0;
  assign dbg_demo_state_o = DEMO_IDLE;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q       <= LEFT_RST;
      xrs_q     <= LEFT_RST;
      y_q       <= TOP_RST;
      yrs_q     <= TOP_RST;
      pending_q <= 1'b0;
    end else begin
      pending_q <= bus.next_frame ? 1'b0 : (pending_q | wr_ok);
      if (bus.next_frame) begin
        x_q   <= left_d;
        xrs_q <= left_d;
        y_q   <= top_d;
        yrs_q <= top_d;
      end else if (bus.next_row) begin
        x_q   <= xrs_q;
        yrs_q <= yrs_q - step_y;
        y_q   <= yrs_q - step_y;
      end else if (bus.next_pixel) begin
        x_q <= x_q + step_x;
      end
    end
  end

  assign bus.x0          = x_q;
  assign bus.y0          = y_q;
  assign bus.cfg_pending = pending_q;

endmodule

// File: tb/tb_coord_stepper.sv
// Directed bench for coord_stepper: spec-level model checked every cycle plus
// hand-computed literal checks; adapts to COORD_DEMO_ZOOM_EN.
module tb_coord_stepper;
  import mandel_coord_pkg::*;

`ifdef COORD_DEMO_ZOOM_EN
  localparam bit DEMO = 1'b1;
`else
  localparam bit DEMO = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  demo_state_e dbg_state;
  int          n_assert;
  int          n_fail;
  bit          chk_en;

  coord_stepper_if #(.BITS(16)) bus ();

  coord_stepper #(.BITS(16), .SCALE_BITS(10), .H_PIXELS(640), .V_PIXELS(480), .MIN_SCALE(16))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus), .dbg_demo_state_o(dbg_state));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [15:0] m_x, m_xrs, m_left, s_left;
  logic [14:0] m_y, m_yrs, m_top, s_top;
  logic [9:0]  m_scale, s_scale;
  bit          m_pend, m_upd;

  task automatic model_reset();
    m_left = 16'hC000; s_left = 16'hC000;
    m_top  = 15'h3000; s_top  = 15'h3000;
    m_scale = 10'd240; s_scale = 10'd240;
    m_x = m_left; m_xrs = m_left; m_y = m_top; m_yrs = m_top;
    m_pend = 1'b0; m_upd = 1'b0;
  endtask

  task automatic model_step();
    bit          wr_ok, commit, upd_next;
    logic [9:0]  old_scale;
    wr_ok = bus.cfg_wr && (bus.cfg_addr != 2'd3);
    if (wr_ok) begin
      case (bus.cfg_addr)
        2'd0: s_left  = {bus.cfg_data, 3'b000};
        2'd1: s_top   = {bus.cfg_data, 2'b00};
        default: s_scale = bus.cfg_data[9:0];
      endcase
    end
    commit    = bus.next_frame && (m_pend || wr_ok);
    old_scale = m_scale;
    if (commit) begin
      m_left = s_left; m_top = s_top; m_scale = s_scale;
    end else if (m_upd) begin
      if (int'(m_scale) - 1 < 16) begin
        m_left = 16'hC000; m_top = 15'h3000; m_scale = 10'd240;
      end else begin
        m_scale = m_scale - 10'd1;
        m_left  = m_left + 16'd320;
        m_top   = m_top - 15'd240;
      end
    end
    upd_next = DEMO && !m_upd && bus.next_frame && bus.demo_en && !commit;
    if (bus.next_frame) m_pend = 1'b0;
    else if (wr_ok)     m_pend = 1'b1;
    if (bus.next_frame) begin
      m_x = m_left; m_xrs = m_left; m_y = m_top; m_yrs = m_top;
    end else if (bus.next_row) begin
      m_yrs = m_yrs - 15'(old_scale);
      m_x = m_xrs; m_y = m_yrs;
    end else if (bus.next_pixel) begin
      m_x = m_x + 16'(old_scale);
    end
    m_upd = upd_next;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && rst_n) begin
        check("model_x0", 32'(bus.x0), 32'(m_x));
        check("model_y0", 32'(bus.y0), 32'(m_y));
        check("model_pending", 32'(bus.cfg_pending), 32'(m_pend));
        check("model_busy", 32'(bus.demo_busy), 32'(m_upd));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input bit nf, input bit nr, input bit np,
                      input bit wr, input logic [1:0] a, input logic [12:0] d);
    bus.next_frame = nf; bus.next_row = nr; bus.next_pixel = np;
    bus.cfg_wr = wr; bus.cfg_addr = a; bus.cfg_data = d;
    @(negedge clk);
    bus.next_frame = 1'b0; bus.next_row = 1'b0; bus.next_pixel = 1'b0;
    bus.cfg_wr = 1'b0;
  endtask

  task automatic frame();               step(1, 0, 0, 0, 2'd0, 13'd0); endtask
  task automatic row();                 step(0, 1, 0, 0, 2'd0, 13'd0); endtask
  task automatic pixel();               step(0, 0, 1, 0, 2'd0, 13'd0); endtask
  task automatic idle();                step(0, 0, 0, 0, 2'd0, 13'd0); endtask
  task automatic wr(input logic [1:0] a, input logic [12:0] d); step(0, 0, 0, 1, a, d); endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_assert = 0; n_fail = 0; chk_en = 1'b0;
    rst_n = 1'b0;
    bus.cfg_wr = 1'b0; bus.cfg_addr = 2'd0; bus.cfg_data = '0; bus.demo_en = 1'b0;
    bus.next_pixel = 1'b0; bus.next_row = 1'b0; bus.next_frame = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_x0", 32'(bus.x0), 32'hC000);
    check("rst_y0", 32'(bus.y0), 32'h3000);
    check("rst_pending", 32'(bus.cfg_pending), 32'h0);
    check("rst_busy", 32'(bus.demo_busy), 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    frame();  check("frame_x0", 32'(bus.x0), 32'hC000); check("frame_y0", 32'(bus.y0), 32'h3000);
    pixel();  check("pix1_x0", 32'(bus.x0), 32'hC0F0);
    pixel();  check("pix2_x0", 32'(bus.x0), 32'hC1E0);
    row();    check("row1_x0", 32'(bus.x0), 32'hC000); check("row1_y0", 32'(bus.y0), 32'h2F10);
    row();    check("row2_y0", 32'(bus.y0), 32'h2E20);

    wr(2'd2, 13'd100); check("scale_wr_pending", 32'(bus.cfg_pending), 32'h1);
    pixel();  check("shadow_step_x0", 32'(bus.x0), 32'hC0F0);
    frame();  check("commit_pending", 32'(bus.cfg_pending), 32'h0);
    pixel();  check("new_step_x0", 32'(bus.x0), 32'hC064);

    step(1, 0, 0, 1, 2'd0, 13'h0100);
    check("same_cycle_commit_x0", 32'(bus.x0), 32'h0800);
    check("same_cycle_pending", 32'(bus.cfg_pending), 32'h0);

    wr(2'd0, 13'h1800); wr(2'd2, 13'd240); frame();
    check("restore_x0", 32'(bus.x0), 32'hC000);
    wr(2'd3, 13'h1FFF); check("rsvd_pending", 32'(bus.cfg_pending), 32'h0);

    bus.demo_en = 1'b1; frame();
    check("demo_busy_on", 32'(bus.demo_busy), DEMO ? 32'h1 : 32'h0);
    bus.demo_en = 1'b0; idle();
    check("demo_busy_off", 32'(bus.demo_busy), 32'h0);
    frame();
    check("demo_frame_x0", 32'(bus.x0), DEMO ? 32'hC140 : 32'hC000);
    check("demo_frame_y0", 32'(bus.y0), DEMO ? 32'h2F10 : 32'h3000);
    pixel();
    check("demo_step_x0", 32'(bus.x0), DEMO ? 32'hC22F : 32'hC0F0);
    row();
    check("demo_row_y0", 32'(bus.y0), DEMO ? 32'h2E21 : 32'h2F10);

    wr(2'd0, 13'h1800); wr(2'd1, 13'h0C00); wr(2'd2, 13'd16); frame();
    check("min_commit_x0", 32'(bus.x0), 32'hC000);
    bus.demo_en = 1'b1; frame();
    bus.demo_en = 1'b0; idle(); frame();
    check("wrap_x0", 32'(bus.x0), 32'hC000);
    check("wrap_y0", 32'(bus.y0), 32'h3000);
    pixel();
    check("wrap_step_x0", 32'(bus.x0), DEMO ? 32'hC0F0 : 32'hC010);

    pixel(); wr(2'd2, 13'd50);
    check("pre_rst_pending", 32'(bus.cfg_pending), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_x0", 32'(bus.x0), 32'hC000);
    check("async_rst_y0", 32'(bus.y0), 32'h3000);
    check("async_rst_pending", 32'(bus.cfg_pending), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    pixel();  check("post_rst_x0", 32'(bus.x0), 32'hC0F0);
    repeat (2) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
